// File: rtl/echo_sample_sequencer.sv
// Per-sample sequencer: converters -> estimator (adapt phase) -> canceller -> output load.
// Latency tick->out_load 7 cycles adapting / 5 frozen; waits on level readies, aborts after TIMEOUT.
module echo_sample_sequencer #(
  parameter int TIMEOUT       = 1024,
  parameter int WARMUP_CANCEL = 2,
  parameter int WARMUP_ADAPT  = 4,
  parameter int ADAPT_SAMPLES = 400,
  parameter int CNT_W         = 24
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [12:0] sampling_cycle_counter,
  output logic        conv_start,
  input  logic        conv_ready_a,
  input  logic        conv_ready_b,
  output logic        adapt_start,
  input  logic        adapt_ready,
  output logic        cancel_start,
  input  logic        cancel_ready,
  input  logic [63:0] e,
  input  logic [63:0] signal_without_echo,
  output logic [63:0] out_double,
  output logic        out_load,
  output logic        sampling_en_cancel,
  output logic        sampling_en_adapt,
  output logic        adapting,
  output logic [31:0] iteration,
  output logic [7:0]  timeout_count,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CONV_START,
    CONV_WAIT,
    ADAPT_START,
    ADAPT_WAIT,
    CANCEL_START,
    CANCEL_WAIT,
    OUTPUT
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADAPT_N  = CNT_W'(ADAPT_SAMPLES);
  localparam logic [CNT_W-1:0] WARM_C_N = CNT_W'(WARMUP_CANCEL);
  localparam logic [CNT_W-1:0] WARM_A_N = CNT_W'(WARMUP_ADAPT);

  state_t           state, state_nxt;
  logic [12:0]      prev_cnt;
  logic [CNT_W-1:0] sample_count;
  logic [TMR_W-1:0] wait_cnt;
  logic             tick;
  logic             is_wait;
  logic             ready_ok;
  logic             timeout_hit;

  assign tick               = enable && (sampling_cycle_counter == 13'd0) && (prev_cnt != 13'd0);
  assign adapting           = sample_count < ADAPT_N;
  assign sampling_en_cancel = sample_count >= WARM_C_N;
  assign sampling_en_adapt  = (sample_count >= WARM_A_N) && adapting;
  assign busy               = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    is_wait     = 1'b0;
    ready_ok    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:         if (tick) state_nxt = CONV_START;
      CONV_START:   state_nxt = CONV_WAIT;
      CONV_WAIT: begin
        is_wait  = 1'b1;
        ready_ok = conv_ready_a && conv_ready_b;
        if (ready_ok) state_nxt = adapting ? ADAPT_START : CANCEL_START;
      end
      ADAPT_START:  state_nxt = ADAPT_WAIT;
      ADAPT_WAIT: begin
        is_wait  = 1'b1;
        ready_ok = adapt_ready;
        if (ready_ok) state_nxt = CANCEL_START;
      end
      CANCEL_START: state_nxt = CANCEL_WAIT;
      CANCEL_WAIT: begin
        is_wait  = 1'b1;
        ready_ok = cancel_ready;
        if (ready_ok) state_nxt = OUTPUT;
      end
      OUTPUT:       state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
    // Ready on the last allowed wait cycle still wins over the abort.
    if (is_wait && !ready_ok && (wait_cnt == TMR_W'(TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
      state_nxt   = IDLE;
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state         <= IDLE;
      prev_cnt      <= '1;
      sample_count  <= '0;
      wait_cnt      <= '0;
      conv_start    <= 1'b0;
      adapt_start   <= 1'b0;
      cancel_start  <= 1'b0;
      out_load      <= 1'b0;
      out_double    <= '0;
      iteration     <= '0;
      timeout_count <= '0;
      overrun       <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev_cnt     <= sampling_cycle_counter;
      conv_start   <= (state_nxt == CONV_START);
      adapt_start  <= (state_nxt == ADAPT_START);
      cancel_start <= (state_nxt == CANCEL_START);
      out_load     <= (state_nxt == OUTPUT);
      wait_cnt     <= is_wait ? wait_cnt + TMR_W'(1) : '0;
      if (tick && state == IDLE && sample_count != '1)
        sample_count <= sample_count + CNT_W'(1);
      if (tick && state != IDLE)
        overrun <= 1'b1;
      if (state == CANCEL_WAIT && cancel_ready)
        out_double <= adapting ? e : signal_without_echo;
      if (state == OUTPUT && adapting)
        iteration <= iteration + 32'd1;
      if (timeout_hit && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_echo_sample_sequencer.sv
// Randomized bench for echo_sample_sequencer against a per-sample timeline model.
module tb_echo_sample_sequencer;
  localparam int TO = 16;
  localparam int WC = 2;
  localparam int WA = 4;
  localparam int AS = 6;

  logic        clk_operation = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [12:0] sampling_cycle_counter = 13'd5;
  logic        conv_ready_a = 1'b0, conv_ready_b = 1'b0, adapt_ready = 1'b0, cancel_ready = 1'b0;
  logic [63:0] e = '0, signal_without_echo = '0;
  logic        conv_start, adapt_start, cancel_start, out_load;
  logic [63:0] out_double;
  logic        sampling_en_cancel, sampling_en_adapt, adapting, overrun, busy;
  logic [31:0] iteration;
  logic [7:0]  timeout_count;

  echo_sample_sequencer #(.TIMEOUT(TO), .WARMUP_CANCEL(WC), .WARMUP_ADAPT(WA),
                          .ADAPT_SAMPLES(AS), .CNT_W(24)) dut (
    .clk_operation(clk_operation), .rst(rst), .enable(enable),
    .sampling_cycle_counter(sampling_cycle_counter),
    .conv_start(conv_start), .conv_ready_a(conv_ready_a), .conv_ready_b(conv_ready_b),
    .adapt_start(adapt_start), .adapt_ready(adapt_ready),
    .cancel_start(cancel_start), .cancel_ready(cancel_ready),
    .e(e), .signal_without_echo(signal_without_echo),
    .out_double(out_double), .out_load(out_load),
    .sampling_en_cancel(sampling_en_cancel), .sampling_en_adapt(sampling_en_adapt),
    .adapting(adapting), .iteration(iteration), .timeout_count(timeout_count),
    .overrun(overrun), .busy(busy));

  always #5 clk_operation = ~clk_operation;

  int errors = 0;
  int checks = 0;

  // Reference state: accepted samples, completed adapting samples, aborts, sticky overrun, last output.
  int          m_cnt;
  logic [31:0] m_iter;
  int          m_to;
  bit          m_ovr;
  logic [63:0] m_out;

  task automatic cyc();
    @(posedge clk_operation);
    #1;
  endtask

  function automatic int max1(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  // One sample: readies rise d cycles after their start pulse; xtick injects a boundary mid-sample.
  task automatic run_sample(input int da, input int db, input int dad, input int dcn,
                            input bit hang, input int xtick, input bit en_drop, input int gap);
    int cs, as_t, cn, ol, end_c, n, exp_to;
    bit ad, exp_ovr;
    logic [31:0] exp_iter;
    logic [63:0] old_out, cap_e, cap_s, exp_out;
    for (int g = 0; g < gap; g++) begin
      cyc();
      enable = 1'b1;
      sampling_cycle_counter = 13'(200 + g);
      conv_ready_a = 1'b0; conv_ready_b = 1'b0; adapt_ready = 1'b0; cancel_ready = 1'b0;
    end
    if (m_cnt < (1 << 24) - 1) m_cnt++;
    ad   = (m_cnt < AS);
    cs   = 1;
    cn   = cs + max1((da > db) ? da : db) + 1;
    as_t = -1;
    if (ad) begin
      as_t = cn;
      cn   = as_t + max1(dad) + 1;
    end
    if (hang) begin
      ol    = -1;
      end_c = cn + TO + 1;
    end else begin
      ol    = cn + max1(dcn) + 1;
      end_c = ol + 1;
    end
    n        = end_c + 1;
    old_out  = m_out;
    cap_e    = '0;
    cap_s    = '0;
    exp_iter = m_iter + ((ad && !hang) ? 32'd1 : 32'd0);
    exp_to   = hang ? ((m_to < 255) ? m_to + 1 : 255) : m_to;
    exp_ovr  = m_ovr || (xtick > 0);
    for (int c = 0; c <= n; c++) begin
      cyc();
      checks += 5;
      if (conv_start !== (c == cs)) begin
        errors++; $display("FAIL conv_start cyc%0d got %b want %b", c, conv_start, c == cs);
      end
      if (adapt_start !== (c == as_t)) begin
        errors++; $display("FAIL adapt_start cyc%0d got %b want %b", c, adapt_start, c == as_t);
      end
      if (cancel_start !== (c == cn)) begin
        errors++; $display("FAIL cancel_start cyc%0d got %b want %b", c, cancel_start, c == cn);
      end
      if (out_load !== (c == ol)) begin
        errors++; $display("FAIL out_load cyc%0d got %b want %b", c, out_load, c == ol);
      end
      if (busy !== (c >= 1 && c < end_c)) begin
        errors++; $display("FAIL busy cyc%0d got %b want %b", c, busy, c >= 1 && c < end_c);
      end
      exp_out = (ol >= 0 && c >= ol) ? (ad ? cap_e : cap_s) : old_out;
      checks++;
      if (out_double !== exp_out) begin
        errors++; $display("FAIL out_double cyc%0d got %h want %h", c, out_double, exp_out);
      end
      if (c == n) begin
        checks += 6;
        if (iteration !== exp_iter) begin
          errors++; $display("FAIL iteration got %0d want %0d", iteration, exp_iter);
        end
        if (timeout_count !== 8'(exp_to)) begin
          errors++; $display("FAIL timeout_count got %0d want %0d", timeout_count, exp_to);
        end
        if (overrun !== exp_ovr) begin
          errors++; $display("FAIL overrun got %b want %b", overrun, exp_ovr);
        end
        if (adapting !== (m_cnt < AS)) begin
          errors++; $display("FAIL adapting cnt%0d got %b want %b", m_cnt, adapting, m_cnt < AS);
        end
        if (sampling_en_cancel !== (m_cnt >= WC)) begin
          errors++; $display("FAIL en_cancel cnt%0d got %b want %b", m_cnt, sampling_en_cancel, m_cnt >= WC);
        end
        if (sampling_en_adapt !== (m_cnt >= WA && m_cnt < AS)) begin
          errors++; $display("FAIL en_adapt cnt%0d got %b want %b", m_cnt, sampling_en_adapt,
                             m_cnt >= WA && m_cnt < AS);
        end
      end
      enable                 = !(en_drop && c >= 2);
      sampling_cycle_counter = (c == 0 || c == xtick) ? 13'd0 : 13'(c + 1);
      conv_ready_a           = (c >= cs + da);
      conv_ready_b           = (c >= cs + db);
      adapt_ready            = ad && (c >= as_t + dad);
      cancel_ready           = !hang && (c >= cn + dcn);
      e                      = {$urandom, $urandom};
      signal_without_echo    = {$urandom, $urandom};
      if (c == ol - 1) begin
        cap_e = e;
        cap_s = signal_without_echo;
      end
    end
    m_iter = exp_iter;
    m_to   = exp_to;
    m_ovr  = exp_ovr;
    if (!hang) m_out = ad ? cap_e : cap_s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks += 13;
    if (conv_start !== 1'b0)   begin errors++; $display("FAIL rst_conv_start got %b want 0", conv_start); end
    if (adapt_start !== 1'b0)  begin errors++; $display("FAIL rst_adapt_start got %b want 0", adapt_start); end
    if (cancel_start !== 1'b0) begin errors++; $display("FAIL rst_cancel_start got %b want 0", cancel_start); end
    if (out_load !== 1'b0)     begin errors++; $display("FAIL rst_out_load got %b want 0", out_load); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (overrun !== 1'b0)      begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
    if (out_double !== 64'd0)  begin errors++; $display("FAIL rst_out_double got %h want 0", out_double); end
    if (iteration !== 32'd0)   begin errors++; $display("FAIL rst_iteration got %0d want 0", iteration); end
    if (timeout_count !== 8'd0) begin errors++; $display("FAIL rst_timeout_count got %0d want 0", timeout_count); end
    if (adapting !== 1'b1)     begin errors++; $display("FAIL rst_adapting got %b want 1", adapting); end
    if (sampling_en_cancel !== 1'b0) begin errors++; $display("FAIL rst_en_cancel got %b want 0", sampling_en_cancel); end
    if (sampling_en_adapt !== 1'b0)  begin errors++; $display("FAIL rst_en_adapt got %b want 0", sampling_en_adapt); end
    if (sampling_en_adapt !== 1'b0 || sampling_en_cancel !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_idle_flags got %b%b%b want 000", sampling_en_adapt, sampling_en_cancel, busy); end
    rst = 1'b0;
    m_cnt = 0; m_iter = '0; m_to = 0; m_ovr = 1'b0; m_out = '0;
  endtask

  task automatic test_adapt_basic();
    for (int i = 0; i < 3; i++) run_sample(0, 0, 0, 0, 1'b0, 0, 1'b0, 55);
  endtask

  task automatic test_reset_mid_sample();
    int n_conv = 0, n_adapt = 0, n_load = 0;
    logic [63:0] ev;
    ev = {$urandom, $urandom};
    for (int c = 0; c <= 6; c++) begin
      cyc();
      if (c == 3) begin
        checks++;
        if (adapt_start !== 1'b1) begin errors++; $display("FAIL pre_rst_adapt_start got %b want 1", adapt_start); end
      end
      sampling_cycle_counter = (c == 0) ? 13'd0 : 13'(c + 1);
      conv_ready_a = 1'b1; conv_ready_b = 1'b1; adapt_ready = 1'b0; cancel_ready = 1'b0;
      rst = (c == 6);
    end
    cyc();
    checks += 6;
    if (busy !== 1'b0)        begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (iteration !== 32'd0)  begin errors++; $display("FAIL mid_rst_iteration got %0d want 0", iteration); end
    if (out_double !== 64'd0) begin errors++; $display("FAIL mid_rst_out_double got %h want 0", out_double); end
    if (sampling_en_cancel !== 1'b0) begin errors++; $display("FAIL mid_rst_en_cancel got %b want 0", sampling_en_cancel); end
    if (adapt_start !== 1'b0 || conv_start !== 1'b0 || cancel_start !== 1'b0 || out_load !== 1'b0)
      begin errors++; $display("FAIL mid_rst_pulses got %b%b%b%b want 0000", conv_start, adapt_start, cancel_start, out_load); end
    if (adapting !== 1'b1)    begin errors++; $display("FAIL mid_rst_adapting got %b want 1", adapting); end
    rst = 1'b0;
    sampling_cycle_counter = 13'd0;
    conv_ready_a = 1'b1; conv_ready_b = 1'b1; adapt_ready = 1'b1; cancel_ready = 1'b1;
    e = ev; signal_without_echo = ~ev;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_conv  += int'(conv_start);
      n_adapt += int'(adapt_start);
      n_load  += int'(out_load);
    end
    checks += 5;
    if (n_conv != 1)  begin errors++; $display("FAIL held_zero_conv_starts got %0d want 1", n_conv); end
    if (n_adapt != 1) begin errors++; $display("FAIL held_zero_adapt_starts got %0d want 1", n_adapt); end
    if (n_load != 1)  begin errors++; $display("FAIL held_zero_loads got %0d want 1", n_load); end
    if (iteration !== 32'd1) begin errors++; $display("FAIL held_zero_iteration got %0d want 1", iteration); end
    if (out_double !== ev)   begin errors++; $display("FAIL held_zero_out_double got %h want %h", out_double, ev); end
    sampling_cycle_counter = 13'd7;
    cyc();
    m_cnt = 1; m_iter = 32'd1; m_to = 0; m_ovr = 1'b0; m_out = ev;
  endtask

  task automatic test_overrun();
    run_sample(2, 10, 1, 1, 1'b0, 6, 1'b0, 5);
    for (int i = 0; i < 2; i++)
      run_sample($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 6), 1'b0, 0, 1'b0, $urandom_range(0, 8));
  endtask

  task automatic test_random(input int cnt, input int gap_max);
    for (int i = 0; i < cnt; i++)
      run_sample($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 6), 1'b0, 0, 1'b0, $urandom_range(0, gap_max));
  endtask

  task automatic test_timeout();
    run_sample($urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 1'b1, 0, 1'b0, 4);
    run_sample(0, 0, 0, 0, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_enable();
    run_sample(1, 3, 0, 2, 1'b0, 0, 1'b1, 4);
    for (int c = 0; c <= 5; c++) begin
      cyc();
      if (c >= 2) begin
        checks++;
        if (busy !== 1'b0 || conv_start !== 1'b0) begin
          errors++; $display("FAIL disabled_tick cyc%0d busy %b conv_start %b want 0 0", c, busy, conv_start);
        end
      end
      enable = 1'b0;
      sampling_cycle_counter = (c == 1) ? 13'd0 : 13'(50 + c);
    end
    enable = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_adapt_basic();
    test_reset_mid_sample();
    test_overrun();
    test_random(1, 10);
    test_random(4, 10);
    test_timeout();
    test_enable();
    test_random(4, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/echo_sample_sequencer.md
Name: echo_sample_sequencer

Overview:
- Per-sample FSM controller for the echo-cancellation datapath. It replaces delay-based sequencing with ready handshakes.
- On each sample boundary it starts the two 16b→double converters, then the NLMS parameter estimator (adaptation phase only), then the canceller. It then loads the selected double result into the double→16b output converter.
- It also owns warm-up gating, the adapt/freeze phase decision, the iteration count and error/overrun status.

Parameters:
- TIMEOUT, 1024, max cycles any wait state may last before the sample is aborted.
- WARMUP_CANCEL, 2, accepted samples before sampling_en_cancel asserts.
- WARMUP_ADAPT, 4, accepted samples before sampling_en_adapt may assert.
- ADAPT_SAMPLES, 400, accepted samples during which adaptation runs; freeze afterwards.
- CNT_W, 24, width of sample_count (saturating).

Ports:
- clk_operation  in  1  operation clock
- rst  in  1  synchronous active-high reset
- enable  in  1  global run enable
- sampling_cycle_counter  in  13  position within the sample period; 0 marks a sample boundary
- conv_start  out  1  1-cycle start pulse to both 16b→double converters
- conv_ready_a, conv_ready_b  in  1  level ready from the converters
- adapt_start  out  1  1-cycle start pulse to the parameter estimator
- adapt_ready  in  1  level ready from the estimator
- cancel_start  out  1  1-cycle start pulse to the canceller
- cancel_ready  in  1  level ready from the canceller
- e  in  64  estimator error (double)
- signal_without_echo  in  64  canceller output (double)
- out_double  out  64  value for the output converter
- out_load  out  1  1-cycle load/enable pulse to the output converter
- sampling_en_cancel, sampling_en_adapt  out  1  sampling enables to canceller / estimator
- adapting  out  1  1 while sample_count < ADAPT_SAMPLES
- iteration  out  32  count of completed adapting samples
- timeout_count  out  8  saturating count of aborted samples
- overrun  out  1  sticky: boundary arrived while busy
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-sample):
  - state=IDLE; all start pulses, out_load, busy and overrun = 0.
  - out_double=0, iteration=0, timeout_count=0, sample_count=0.
  - prev_cnt = all-ones.
- Tick detection:
  - tick = enable && sampling_cycle_counter==0 && prev_cnt!=0.
  - prev_cnt registers sampling_cycle_counter every cycle. A counter held at 0 therefore gives exactly one tick.
- Tick acceptance:
  - Tick in IDLE: accepted; sample_count increments (saturating at 2^CNT_W−1); go CONV_START.
  - Tick while not IDLE: dropped; overrun←1 (sticky until rst); sample_count unchanged.
- Derived flags (combinational from sample_count):
  - adapting = sample_count < ADAPT_SAMPLES.
  - sampling_en_cancel = sample_count >= WARMUP_CANCEL.
  - sampling_en_adapt = (sample_count >= WARMUP_ADAPT) && adapting.
  - Reset values follow from sample_count=0.
- States and transitions (start pulses are registered and high only during their *_START state):
  - IDLE: wait for tick.
  - CONV_START: conv_start=1 → CONV_WAIT.
  - CONV_WAIT: on conv_ready_a && conv_ready_b → ADAPT_START if adapting, else CANCEL_START.
  - ADAPT_START: adapt_start=1 → ADAPT_WAIT.
  - ADAPT_WAIT: on adapt_ready → CANCEL_START.
  - CANCEL_START: cancel_start=1 → CANCEL_WAIT.
  - CANCEL_WAIT: on cancel_ready → OUTPUT. On this same edge out_double ← (adapting ? e : signal_without_echo).
  - OUTPUT: out_load=1; iteration+1 if adapting (wraps at 2^32) → IDLE.
- Ready sampling: ready inputs are sampled only in *_WAIT states. A ready already high during the start-pulse cycle is not acted on until the first WAIT cycle.
- Adapt path decision: adapting is evaluated at the CONV_WAIT exit and at the CANCEL_WAIT exit. Both decisions see the same sample_count within one sample.
- Timeout:
  - Per-state counter clears on entering each WAIT state.
  - If ready is not seen within TIMEOUT WAIT cycles: timeout_count+1 (saturate at 255), go to IDLE, no out_load, iteration unchanged, out_double held.
- Latency: tick seen in cycle T with all readies already high:
  - Adapting: out_load high in cycle T+7 (CONV_START T+1 … OUTPUT T+7).
  - Frozen: out_load high in cycle T+5.
- enable deasserted mid-sample: the current sample completes normally; no new ticks are accepted.
- out_double holds its value between loads.

Test Plan:
- Reset, then ticks every 64 cycles with all readies tied high → per sample: conv_start, adapt_start, cancel_start each 1 cycle; out_load at T+7; out_double=e; iteration increments 1,2,3.
- ADAPT_SAMPLES=3: run 5 samples → samples 4–5 skip adapt_start; out_load at T+5; out_double=signal_without_echo; iteration stays 3; adapting=0.
- Warm-up: WARMUP_CANCEL=2, WARMUP_ADAPT=4 → sampling_en_cancel rises after tick 2; sampling_en_adapt rises after tick 4.
- cancel_ready held low, TIMEOUT=16 → returns to IDLE 16 WAIT cycles after CANCEL_WAIT entry; timeout_count=1; no out_load; the next sample runs normally.
- Delay conv_ready_b by 100 cycles while a second boundary arrives → overrun=1; that tick is dropped; sample_count incremented only once.
- Assert rst during ADAPT_WAIT → next cycle: all outputs at reset values; sampling_cycle_counter held at 0 afterwards produces exactly one tick.
